// File: rtl/vga_timing_prog.sv
// vga_timing_prog
//   Runtime-programmable VGA/DVI timing generator in the pixel clock domain.
//   Two internal counters (nx, ny) walk the whole frame, including blanking.
//   Screen position, syncs, data enable and the line/frame strobes are decoded
//   from them and registered, so every output lags the counters by one clock
//   and all outputs line up on the same cycle.
//   A new timing set is accepted over a single-entry valid/ready port. It is
//   held as pending and only goes live at the frame wrap, so a frame is never
//   drawn with mixed timing.
//
// Ports
//   clk_pix      in   pixel clock
//   rst_pix_n    in   asynchronous active-low reset
//   cfg_valid    in   config word offered
//   cfg_ready    out  config slot free; a word transfers when valid & ready
//   cfg_h        in   {h_line, h_syn_end, h_syn_sta, h_act_end}
//   cfg_v        in   {v_screen, v_syn_end, v_syn_sta, v_act_end}
//   cfg_pol      in   {v_pol, h_pol}; 1 = active-high sync
//   cfg_applied  out  1-cycle pulse, aligned with frame, when pending config went live
//   sx, sy       out  registered screen position
//   hsync, vsync out  syncs in the live polarity
//   de           out  data enable (active area)
//   line         out  pulse on the last pixel of a line
//   frame        out  pulse on the last pixel of a frame

module vga_timing_prog #(
  parameter int CORDW     = 11,
  parameter int H_ACT_END = 1279,
  parameter int H_SYN_STA = 1287,
  parameter int H_SYN_END = 1319,
  parameter int H_LINE    = 1359,
  parameter int V_ACT_END = 719,
  parameter int V_SYN_STA = 726,
  parameter int V_SYN_END = 734,
  parameter int V_SCREEN  = 740,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0
) (
  input  logic               clk_pix,
  input  logic               rst_pix_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [4*CORDW-1:0] cfg_h,
  input  logic [4*CORDW-1:0] cfg_v,
  input  logic [1:0]         cfg_pol,
  output logic               cfg_applied,
  output logic [CORDW-1:0]   sx,
  output logic [CORDW-1:0]   sy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line,
  output logic               frame
);

  localparam logic [4*CORDW-1:0] DEF_H =
    {CORDW'(H_LINE), CORDW'(H_SYN_END), CORDW'(H_SYN_STA), CORDW'(H_ACT_END)};
  localparam logic [4*CORDW-1:0] DEF_V =
    {CORDW'(V_SCREEN), CORDW'(V_SYN_END), CORDW'(V_SYN_STA), CORDW'(V_ACT_END)};
  localparam logic [1:0] DEF_POL = {V_POL, H_POL};

  // Live timing (drives the counters/decode) and the single-entry shadow.
  logic [4*CORDW-1:0] live_h_reg, live_v_reg, shad_h_reg, shad_v_reg;
  logic [1:0]         live_pol_reg, shad_pol_reg;
  logic               pending_reg;
  logic [CORDW-1:0]   nx_reg, ny_reg;

  // Field views of the live timing.
  logic [CORDW-1:0] h_act_end, h_syn_sta, h_syn_end, h_line;
  logic [CORDW-1:0] v_act_end, v_syn_sta, v_syn_end, v_screen;

  assign {h_line, h_syn_end, h_syn_sta, h_act_end} = live_h_reg;
  assign {v_screen, v_syn_end, v_syn_sta, v_act_end} = live_v_reg;

  logic h_end, v_end, wrap, apply, xfer;
  logic hs_act, vs_act;

  assign h_end  = (nx_reg == h_line);
  assign v_end  = (ny_reg == v_screen);
  assign wrap   = h_end && v_end;
  // A word can only be pending or being accepted, never both, so apply and
  // xfer are mutually exclusive; a word accepted on the wrap waits a frame.
  assign apply  = wrap && pending_reg;
  assign xfer   = cfg_valid && !pending_reg;
  // syn_end <= syn_sta yields an empty window: sync never asserts.
  assign hs_act = (nx_reg >= h_syn_sta) && (nx_reg < h_syn_end);
  assign vs_act = (ny_reg >= v_syn_sta) && (ny_reg < v_syn_end);

  assign cfg_ready = ~pending_reg;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      live_h_reg   <= DEF_H;
      live_v_reg   <= DEF_V;
      live_pol_reg <= DEF_POL;
      shad_h_reg   <= '0;
      shad_v_reg   <= '0;
      shad_pol_reg <= '0;
      pending_reg  <= 1'b0;
      nx_reg       <= '0;
      ny_reg       <= '0;
      cfg_applied  <= 1'b0;
      sx           <= '0;
      sy           <= '0;
      de           <= 1'b0;
      line         <= 1'b0;
      frame        <= 1'b0;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
    end else begin
      if (h_end) begin
        nx_reg <= '0;
        ny_reg <= v_end ? '0 : ny_reg + CORDW'(1);
      end else begin
        nx_reg <= nx_reg + CORDW'(1);
      end

      // New timing lands together with the counter wrap, so pixel (0,0) of
      // the next frame is the first one decoded with it.
      if (apply) begin
        live_h_reg   <= shad_h_reg;
        live_v_reg   <= shad_v_reg;
        live_pol_reg <= shad_pol_reg;
        pending_reg  <= 1'b0;
      end else if (xfer) begin
        shad_h_reg   <= cfg_h;
        shad_v_reg   <= cfg_v;
        shad_pol_reg <= cfg_pol;
        pending_reg  <= 1'b1;
      end

      // Registered decode: everything below is one cycle behind nx/ny and
      // uses the timing that was live when that position was counted.
      cfg_applied <= apply;
      sx          <= nx_reg;
      sy          <= ny_reg;
      de          <= (nx_reg <= h_act_end) && (ny_reg <= v_act_end);
      line        <= h_end;
      frame       <= wrap;
      hsync       <= hs_act ? live_pol_reg[0] : ~live_pol_reg[0];
      vsync       <= vs_act ? live_pol_reg[1] : ~live_pol_reg[1];
    end
  end

endmodule

// File: tb/tb_vga_timing_prog.sv
// Bench for vga_timing_prog. Uses a shrunken default timing (20x10 frame) so
// full frames run quickly. The reference model tracks the position as a flat
// cycle index inside the frame and derives x/y by division.
module tb_vga_timing_prog;

  localparam int CORDW = 11;
  localparam int D_HACT = 11, D_HSS = 13, D_HSE = 16, D_HL = 19;
  localparam int D_VACT = 5,  D_VSS = 6,  D_VSE = 8,  D_VS = 9;

  logic               clk_pix = 1'b0;
  logic               rst_pix_n = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [4*CORDW-1:0] cfg_h = '0;
  logic [4*CORDW-1:0] cfg_v = '0;
  logic [1:0]         cfg_pol = '0;
  logic               cfg_applied;
  logic [CORDW-1:0]   sx, sy;
  logic               hsync, vsync, de, line, frame;

  vga_timing_prog #(
    .CORDW(CORDW),
    .H_ACT_END(D_HACT), .H_SYN_STA(D_HSS), .H_SYN_END(D_HSE), .H_LINE(D_HL),
    .V_ACT_END(D_VACT), .V_SYN_STA(D_VSS), .V_SYN_END(D_VSE), .V_SCREEN(D_VS),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol),
    .cfg_applied(cfg_applied),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync),
    .de(de), .line(line), .frame(frame)
  );

  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int failures = 0;

  // Reference model: live/shadow timing as {act_end, syn_sta, syn_end, last}.
  int unsigned l_h[4], l_v[4], s_h[4], s_v[4];
  bit          l_hp, l_vp, s_hp, s_vp, m_pend, m_xfer;
  int unsigned fpos;
  int unsigned e_sx, e_sy;
  bit          e_de, e_line, e_frame, e_hs, e_vs, e_app, e_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4*CORDW-1:0] pack4(input int unsigned act, input int unsigned sta,
                                               input int unsigned fin, input int unsigned last);
    return {CORDW'(last), CORDW'(fin), CORDW'(sta), CORDW'(act)};
  endfunction

  function automatic int unsigned frame_len();
    return (l_h[3] + 1) * (l_v[3] + 1);
  endfunction

  task automatic model_reset();
    l_h = '{D_HACT, D_HSS, D_HSE, D_HL};
    l_v = '{D_VACT, D_VSS, D_VSE, D_VS};
    l_hp = 1'b0; l_vp = 1'b0;
    m_pend = 1'b0; m_xfer = 1'b0; fpos = 0;
    e_sx = 0; e_sy = 0; e_de = 0; e_line = 0; e_frame = 0;
    e_hs = 1'b1; e_vs = 1'b1; e_app = 0; e_rdy = 1;
  endtask

  task automatic model_step();
    int unsigned x, y;
    bit pend_b;
    pend_b = m_pend;
    m_xfer = cfg_valid && !pend_b;
    x = fpos % (l_h[3] + 1);
    y = fpos / (l_h[3] + 1);
    e_sx = x; e_sy = y;
    e_de    = (x <= l_h[0]) && (y <= l_v[0]);
    e_line  = (x == l_h[3]);
    e_frame = e_line && (y == l_v[3]);
    e_hs    = (x >= l_h[1] && x < l_h[2]) ? l_hp : !l_hp;
    e_vs    = (y >= l_v[1] && y < l_v[2]) ? l_vp : !l_vp;
    e_app   = e_frame && pend_b;
    if (e_frame) begin
      fpos = 0;
      if (pend_b) begin
        l_h = s_h; l_v = s_v; l_hp = s_hp; l_vp = s_vp;
        m_pend = 1'b0;
      end
    end else begin
      fpos++;
    end
    if (m_xfer) begin
      for (int i = 0; i < 4; i++) begin
        s_h[i] = 32'(cfg_h[i*CORDW +: CORDW]);
        s_v[i] = 32'(cfg_v[i*CORDW +: CORDW]);
      end
      s_hp = cfg_pol[0]; s_vp = cfg_pol[1];
      m_pend = 1'b1;
    end
    e_rdy = !m_pend;
  endtask

  task automatic check_all();
    chk("sx", 32'(sx), e_sx);
    chk("sy", 32'(sy), e_sy);
    chk("de", 32'(de), 32'(e_de));
    chk("line", 32'(line), 32'(e_line));
    chk("frame", 32'(frame), 32'(e_frame));
    chk("hsync", 32'(hsync), 32'(e_hs));
    chk("vsync", 32'(vsync), 32'(e_vs));
    chk("cfg_applied", 32'(cfg_applied), 32'(e_app));
    chk("cfg_ready", 32'(cfg_ready), 32'(e_rdy));
  endtask

  task automatic cycle();
    @(posedge clk_pix);
    if (!rst_pix_n) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  initial begin
    int n, de_cnt, line_cnt, frame_cnt;
    bit found;

    // T1: asynchronous reset, checked before any clock edge
    model_reset();
    #1 rst_pix_n = 1'b0;
    #1 check_all();
    repeat (3) cycle();
    rst_pix_n = 1'b1;

    // T2: default timing, then a whole-frame census of the strobes
    repeat (205) cycle();
    de_cnt = 0; line_cnt = 0; frame_cnt = 0;
    repeat (200) begin
      cycle();
      de_cnt += int'(de); line_cnt += int'(line); frame_cnt += int'(frame);
    end
    chk("t2_de_count", 32'(de_cnt), 32'((D_HACT + 1) * (D_VACT + 1)));
    chk("t2_line_count", 32'(line_cnt), 32'(D_VS + 1));
    chk("t2_frame_count", 32'(frame_cnt), 32'd1);

    // T3: mid-frame reconfig to a 7x4 frame with active-high syncs
    repeat (37) cycle();
    cfg_valid = 1'b1;
    cfg_h = pack4(3, 4, 5, 6);
    cfg_v = pack4(1, 2, 3, 3);
    cfg_pol = 2'b11;
    cycle();
    cfg_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle();
      found = cfg_applied;
    end
    chk("t3_applied_seen", 32'(found), 32'd1);
    n = 0; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      n++;
      found = frame;
    end
    chk("t3_frame_period", 32'(n), 32'd28);

    // T4: back-to-back words; the second waits for cfg_ready
    repeat (5) cycle();
    cfg_valid = 1'b1;
    cfg_h = pack4(2, 1, 2, 4);
    cfg_v = pack4(1, 0, 1, 2);
    cfg_pol = 2'b01;
    cycle();
    chk("t4_first_taken", 32'(m_xfer), 32'd1);
    cfg_h = pack4(5, 6, 8, 9);
    cfg_v = pack4(2, 3, 4, 4);
    cfg_pol = 2'b10;
    cycle();
    chk("t4_second_held", 32'(m_xfer), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      found = m_xfer;
    end
    chk("t4_second_taken", 32'(found), 32'd1);
    cfg_valid = 1'b0;
    repeat (120) cycle();

    // T5: offer a word exactly on the wrap cycle with nothing pending
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (!m_pend && fpos == frame_len() - 1) found = 1'b1;
      else cycle();
    end
    chk("t5_wrap_reached", 32'(found), 32'd1);
    cfg_valid = 1'b1;
    cfg_h = pack4(6, 8, 10, 11);
    cfg_v = pack4(3, 4, 5, 5);
    cfg_pol = 2'b00;
    cycle();
    cfg_valid = 1'b0;
    chk("t5_accepted", 32'(cfg_ready), 32'd0);
    chk("t5_not_applied", 32'(cfg_applied), 32'd0);
    repeat (150) cycle();

    // T6: reset in mid-line with a word pending
    cfg_valid = 1'b1;
    cfg_h = pack4(1, 1, 1, 2);
    cfg_v = pack4(1, 1, 1, 2);
    cfg_pol = 2'b11;
    cycle();
    cfg_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      found = (e_sx == 5);
    end
    chk("t6_sx5_reached", 32'(found), 32'd1);
    rst_pix_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) cycle();
    rst_pix_n = 1'b1;
    repeat (410) cycle();

    // Randomized traffic: sporadic words with arbitrary field values
    for (int i = 0; i < 4000; i++) begin
      cfg_valid = ($urandom_range(0, 29) == 0);
      cfg_h = pack4($urandom_range(0, 17), $urandom_range(0, 17),
                    $urandom_range(0, 17), $urandom_range(0, 15));
      cfg_v = pack4($urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 7));
      cfg_pol = 2'($urandom_range(0, 3));
      cycle();
    end
    cfg_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
